// File: rtl/sr_imem_loader.sv
// rtl/sr_imem_loader.sv - instruction RAM with byte-stream boot loader
// Holds the CPU in reset while little-endian bytes are packed into 32-bit words.
module sr_imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           imAddr,
  output logic [31:0]           imData,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH:0]   ld_len,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic                  cpu_rst_n
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_W   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {HOLD, LOAD, DONE, RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   len, word_cnt, len_clamped;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [1:0]            byte_cnt;
  logic [23:0]           byte_buf;
  logic [31:0]           mem [DEPTH];
  logic                  start_ok, accept, word_wr, last_word;
  logic                  unused_addr_bits;

  assign start_ok    = ld_start && (state == HOLD || state == RUN);
  assign accept      = (state == LOAD) && ld_valid;
  assign word_wr     = accept && (byte_cnt == 2'd3);
  assign last_word   = word_wr && ((word_cnt + ONE_W) == len);
  assign len_clamped = (ld_len > DEPTH_W) ? DEPTH_W : ld_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HOLD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    ld_busy   = 1'b0;
    ld_done   = 1'b0;
    cpu_rst_n = 1'b0;
    case (state)
      HOLD: begin
        if (ld_start) state_nxt = (ld_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        ld_busy   = 1'b1;
        ld_done   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        cpu_rst_n = 1'b1;
        if (ld_start) state_nxt = (ld_len == '0) ? DONE : LOAD;
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= '0;
      word_cnt <= '0;
      waddr    <= '0;
      byte_cnt <= '0;
      byte_buf <= '0;
    end else if (start_ok) begin
      len      <= len_clamped;
      word_cnt <= '0;
      waddr    <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      if (byte_cnt == 2'd3) begin
        byte_cnt <= '0;
        word_cnt <= word_cnt + ONE_W;
        // Stop short of the last increment so waddr never wraps on a full load.
        if (!last_word) waddr <= waddr + ONE_A;
      end else begin
        byte_buf[{byte_cnt, 3'b000} +: 8] <= ld_byte;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  // RAM is deliberately left out of reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (word_wr) mem[waddr] <= {ld_byte, byte_buf};
  end

  assign imData           = mem[imAddr[ADDR_WIDTH-1:0]];
  assign unused_addr_bits = ^imAddr[31:ADDR_WIDTH];

endmodule

// File: tb/tb_sr_imem_loader.sv
// tb/tb_sr_imem_loader.sv - randomized bench for sr_imem_loader
// Reference model tracks RAM words and expected session timing at word level.
module tb_sr_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        ld_start;
  logic [6:0]  ld_len;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_ready, ld_busy, ld_done, cpu_rst_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [64];
  bit          known     [64];
  logic [7:0]  stream    [320];

  sr_imem_loader #(.ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .imAddr(imAddr), .imData(imData),
    .ld_start(ld_start), .ld_len(ld_len), .ld_byte(ld_byte),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit rdy, input bit busy, input bit done, input bit cpu);
    check({tag, ".ld_ready"}, 32'(ld_ready), 32'(rdy));
    check({tag, ".ld_busy"}, 32'(ld_busy), 32'(busy));
    check({tag, ".ld_done"}, 32'(ld_done), 32'(done));
    check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(cpu));
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 64; a++) begin
      if (known[a]) begin
        imAddr = {$urandom_range(0, 3'h7) == 0 ? 26'd0 : 26'($urandom), 6'(a)};
        #0.1;
        check($sformatf("%s.mem[%0d]", tag, a), imData, model_mem[a]);
      end
    end
  endtask

  function automatic logic [31:0] word_of(input int w);
    return {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
  endfunction

  // mode: 0 valid every cycle, 1 valid on alternate cycles, 2 random valid
  task automatic run_load(input string tag, input int len, input int mode);
    int n;
    int acc;
    int cyc;
    bit v;
    n = (len > 64) ? 64 : len;
    acc = 0;
    cyc = 0;
    @(negedge clk);
    ld_start = 1'b1;
    ld_len   = 7'(len);
    ld_valid = 1'b0;
    @(negedge clk);
    ld_start = 1'b0;
    while (acc < 4 * n && cyc < 3000) begin
      check_outs({tag, ".load"}, 1'b1, 1'b1, 1'b0, 1'b0);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      ld_valid = v;
      ld_byte  = v ? stream[acc] : 8'($urandom);
      ld_start = 1'($urandom);
      ld_len   = 7'($urandom);
      @(negedge clk);
      if (v) acc++;
      cyc++;
    end
    check({tag, ".bytes_accepted"}, 32'(acc), 32'(4 * n));
    ld_valid = 1'b0;
    ld_start = 1'b0;
    check_outs({tag, ".done"}, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int w = 0; w < n; w++) begin
      model_mem[w] = word_of(w);
      known[w] = 1'b1;
    end
    // ld_start is ignored while DONE
    ld_start = 1'($urandom);
    ld_len   = 7'($urandom_range(1, 100));
    @(negedge clk);
    ld_start = 1'b0;
    check_outs({tag, ".run"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle_bytes(input string tag, input int cycles, input bit cpu);
    for (int i = 0; i < cycles; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'($urandom);
      @(negedge clk);
      check_outs(tag, 1'b0, 1'b0, 1'b0, cpu);
    end
    ld_valid = 1'b0;
  endtask

  task automatic set_stream(input logic [63:0] b);
    for (int i = 0; i < 8; i++) stream[i] = b[63 - 8*i -: 8];
  endtask

  initial begin
    logic [63:0] prog;
    for (int i = 0; i < 64; i++) known[i] = 1'b0;
    rst = 1'b1; imAddr = '0; ld_start = 1'b0; ld_len = '0;
    ld_byte = '0; ld_valid = 1'b0;

    // 1: reset state, stays in HOLD and ignores bytes
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_bytes("hold", 4, 1'b0);

    // 2: two-word load, valid every cycle
    prog = 64'h13_00_50_00_B3_00_10_00;
    set_stream(prog);
    run_load("t2", 2, 0);
    imAddr = 32'd1;
    #1;
    check("t2.imData1", imData, 32'h001000B3);
    imAddr = 32'd0;
    #1;
    check("t2.imData0", imData, 32'h00500013);
    idle_bytes("run", 3, 1'b1);

    // 3: same stream with valid on alternate cycles, first scribble different words
    for (int i = 0; i < 8; i++) stream[i] = 8'($urandom);
    run_load("t3pre", 2, 2);
    check_all("t3pre");
    set_stream(prog);
    run_load("t3", 2, 1);
    check_all("t3");

    // 6: reload from RUN with clamped length
    for (int i = 0; i < 320; i++) stream[i] = 8'($urandom);
    run_load("t6", 70, 2);
    check_all("t6");
    idle_bytes("t6.run", 3, 1'b1);

    // 4: zero-length session
    run_load("t4", 0, 0);
    check_all("t4");

    // 5: reset after five bytes of a two-word load
    for (int i = 0; i < 8; i++) stream[i] = 8'($urandom);
    @(negedge clk);
    ld_start = 1'b1;
    ld_len   = 7'd2;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_byte  = stream[i];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_outs("t5.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    model_mem[0] = word_of(0);
    check_all("t5.rst");
    @(negedge clk);
    rst = 1'b0;
    idle_bytes("t5.hold", 2, 1'b0);
    set_stream(64'h93_00_00_00_00_00_00_00);
    run_load("t5b", 1, 0);
    imAddr = 32'd0;
    #1;
    check("t5b.imData0", imData, 32'h00000093);
    check_all("t5b");

    // random sessions
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 320; i++) stream[i] = 8'($urandom);
      run_load($sformatf("rnd%0d", s), $urandom_range(0, 80), $urandom_range(0, 2));
      check_all($sformatf("rnd%0d", s));
      idle_bytes("rnd.run", 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
